// File: rtl/fpnew_slice_out_arbiter.sv
// Round-robin merge of the per-format slice outputs of an opgroup into a
// 2-entry result FIFO that feeds the FPU top-level output arbiter.
module fpnew_slice_out_arbiter #(
  parameter int unsigned NumSlices = 4,
  parameter int unsigned Width     = 64,
  parameter type         TagType   = logic
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumSlices-1:0][Width-1:0] slice_result_i,
  input  logic [NumSlices-1:0][4:0]       slice_status_i,
  input  logic [NumSlices-1:0]            slice_ext_bit_i,
  input  TagType [NumSlices-1:0]          slice_tag_i,
  input  logic [NumSlices-1:0]            slice_valid_i,
  output logic [NumSlices-1:0]            slice_ready_o,
  input  logic [NumSlices-1:0]            slice_busy_i,
  input  logic                            flush_i,
  output logic [Width-1:0]                result_o,
  output logic [4:0]                      status_o,
  output logic                            extension_bit_o,
  output TagType                          tag_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o
);

  localparam int unsigned IdxW = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0]       prio_q, prio_d;
  logic [1:0][Width-1:0] result_q, result_d;
  logic [1:0][4:0]       status_q, status_d;
  logic [1:0]            ext_q, ext_d;
  TagType [1:0]          tag_q, tag_d;

  logic [NumSlices-1:0]  grant;
  logic [IdxW-1:0]       grant_idx;
  logic                  grant_found;
  logic                  hit;
  int unsigned           cand;
  logic                  full, empty, push, pop;

  // Search upward from the priority pointer, wrapping, for the first valid slice.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    hit         = 1'b0;
    cand        = 32'd0;
    for (int unsigned k = 0; k < NumSlices; k++) begin
      cand        = (32'(prio_q) + k >= NumSlices) ? (32'(prio_q) + k - NumSlices)
                                                   : (32'(prio_q) + k);
      hit         = ~grant_found & slice_valid_i[IdxW'(cand)];
      grant_idx   = hit ? IdxW'(cand) : grant_idx;
      grant_found = grant_found | hit;
    end
    grant[grant_idx] = grant_found;
  end

  assign full          = (count_q == 2'd2);
  assign empty         = (count_q == 2'd0);
  assign slice_ready_o = grant & {NumSlices{~full & ~flush_i}};
  assign push          = |(slice_valid_i & slice_ready_o);
  assign pop           = ~empty & out_ready_i & ~flush_i;

  // FIFO write/read bookkeeping and priority update.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    prio_d   = prio_q;
    result_d = result_q;
    status_d = status_q;
    ext_d    = ext_q;
    tag_d    = tag_q;
    if (flush_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        result_d[wr_ptr_q] = slice_result_i[grant_idx];
        status_d[wr_ptr_q] = slice_status_i[grant_idx];
        ext_d[wr_ptr_q]    = slice_ext_bit_i[grant_idx];
        tag_d[wr_ptr_q]    = slice_tag_i[grant_idx];
        wr_ptr_d           = ~wr_ptr_q;
        prio_d             = (32'(grant_idx) + 32'd1 >= NumSlices) ? '0
                                                                   : grant_idx + IdxW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so nothing stale survives.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      prio_q   <= '0;
      result_q <= '0;
      status_q <= '0;
      ext_q    <= 2'b00;
      tag_q    <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      prio_q   <= prio_d;
      result_q <= result_d;
      status_q <= status_d;
      ext_q    <= ext_d;
      tag_q    <= tag_d;
    end
  end

  // Head slot is masked to zero when empty.
  assign out_valid_o     = ~empty;
  assign result_o        = empty ? '0   : result_q[rd_ptr_q];
  assign status_o        = empty ? 5'd0 : status_q[rd_ptr_q];
  assign extension_bit_o = empty ? 1'b0 : ext_q[rd_ptr_q];
  assign tag_o           = empty ? '0   : tag_q[rd_ptr_q];
  assign busy_o          = ~empty | (|slice_busy_i);

endmodule
